jtvigil_prio_colmix: RTL and testbench

- Parametrised colour mixer for N tile/sprite layers.
- Resolves per-pixel layer priority from a CPU-programmable rank table plus a per-pixel promote tag.
- Looks up R, G and B from a CPU-shared palette RAM in three time-multiplexed reads.
- Drives blanked RGB to the video output; sits between the layer renderers and the frame video out, successor to the fixed 2-layer-plus-objects mixer.

---
 rtl/jtvigil_colmix_pkg.sv | 26 ++
 rtl/jtvigil_prio_colmix_if.sv | 18 +
 rtl/jtframe_dual_ram.sv | 26 ++
 rtl/jtvigil_prio_colmix_chk.sv | 18 +
 rtl/jtvigil_prio_colmix_sel.sv | 62 ++++++
 rtl/jtvigil_prio_colmix.sv | 103 ++++++++++
 tb/tb_jtvigil_prio_colmix.sv | 194 +++++++++++++++++++
 7 files changed

// File: rtl/jtvigil_colmix_pkg.sv
// Shared constants for the jtvigil priority colour mixer.
// Includes the channel and capture-phase encodings and the reset rank table.
package jtvigil_colmix_pkg;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2,
    CH_X = 2'd3
  } chan_e;

  localparam logic [2:0] PH_R = 3'd1;
  localparam logic [2:0] PH_G = 3'd3;
  localparam logic [2:0] PH_B = 3'd5;

  // Layer i gets rank i, so layer 0 is on top after reset.
  function automatic logic [15:0] default_ranks();
    logic [15:0] r;
    r = 16'd0;
    for (int i = 0; i < 8; i++) begin
      r[2*i +: 2] = 2'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/jtvigil_prio_colmix_if.sv
// CPU-side bus of the colour mixer: palette access plus rank-table writes.
interface jtvigil_prio_colmix_if #(
  parameter int LAYERS = 3,
  parameter int PALAW  = 12
);
  logic [PALAW-1:0]    cpu_addr;
  logic [7:0]          cpu_dout;
  logic                cpu_rnw;
  logic                pal_cs;
  logic [7:0]          cpu_din;
  logic                prio_we;
  logic [2*LAYERS-1:0] prio_din;

  modport master (output cpu_addr, cpu_dout, cpu_rnw, pal_cs, prio_we, prio_din,
                  input  cpu_din);
  modport slave  (input  cpu_addr, cpu_dout, cpu_rnw, pal_cs, prio_we, prio_din,
                  output cpu_din);
endinterface

// File: rtl/jtframe_dual_ram.sv
// Dual-port RAM: port 0 read/write, port 1 read-only, both with a registered read.
// A read on port 1 that collides with a write on port 0 returns the old data.
module jtframe_dual_ram #(
  parameter int dw = 8,
  parameter int aw = 10
) (
  input  logic          clk0,
  input  logic [dw-1:0] data0,
  input  logic [aw-1:0] addr0,
  input  logic          we0,
  output logic [dw-1:0] q0,
  input  logic          clk1,
  input  logic [aw-1:0] addr1,
  output logic [dw-1:0] q1
);
  logic [dw-1:0] mem [2**aw];

  always_ff @(posedge clk0) begin
    if (we0) mem[addr0] <= data0;
    q0 <= mem[addr0];
  end

  always_ff @(posedge clk1) begin
    q1 <= mem[addr1];
  end
endmodule

// File: rtl/jtvigil_prio_colmix_chk.sv
// Simulation checker: pixel clock enables must be at least 8 clk apart.
module jtvigil_prio_colmix_chk (
  input logic clk,
  input logic rst,
  input logic pxl_cen
);
  logic [2:0] gap_r;

  // Clocks since the last pxl_cen, saturating at 7.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                gap_r <= 3'd7;
    else if (pxl_cen)       gap_r <= 3'd0;
    else if (gap_r != 3'd7) gap_r <= gap_r + 3'd1;
  end

  a_cen_period: assert property (@(posedge clk) disable iff (rst) pxl_cen |-> gap_r == 3'd7)
    else $error("pxl_cen period shorter than 8 clk");
endmodule

// File: rtl/jtvigil_prio_colmix_sel.sv
// Per-pixel winner selection across layers, registered on pxl_cen.
// Ties in effective rank go to the higher layer index.
module jtvigil_prio_sel
  import jtvigil_colmix_pkg::*;
#(
  parameter int LAYERS = 3,
  parameter int PXLW   = 8,
  parameter int LW     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pxl_cen,
  input  logic [LAYERS*PXLW-1:0] lyr_pxl,
  input  logic [2*LAYERS-1:0]    ranks,
  input  logic [LAYERS-1:0]      gfx_en,
  output logic [LW-1:0]          sel,
  output logic [PXLW-1:0]        pal_base
);
  logic [LAYERS-1:0] opaque_s;
  logic [1:0]        eff_s [LAYERS];
  logic [LW-1:0]     win_s;
  logic [1:0]        best_s;
  logic              found_s;
  logic [PXLW-1:0]   win_pxl_s;

  // Opacity and effective rank; a promoted opaque pixel jumps to rank 0.
  always_comb begin
    for (int i = 0; i < LAYERS; i++) begin
      opaque_s[i] = (lyr_pxl[i*PXLW +: 4] != 4'd0) && gfx_en[i];
      if (opaque_s[i] && (lyr_pxl[i*PXLW+PXLW-2 +: 2] == 2'b11)) eff_s[i] = 2'd0;
      else                                                       eff_s[i] = ranks[2*i +: 2];
    end
  end

  // Lowest effective rank wins; "<=" lets a later (higher) index take ties.
  always_comb begin
    win_s   = '0;
    best_s  = 2'd3;
    found_s = 1'b0;
    for (int i = 0; i < LAYERS; i++) begin
      if (opaque_s[i] && (!found_s || (eff_s[i] <= best_s))) begin
        win_s   = LW'(i);
        best_s  = eff_s[i];
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    win_pxl_s = lyr_pxl[win_s*PXLW +: PXLW];
  end

  // Stage A register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel      <= '0;
      pal_base <= '0;
    end else if (pxl_cen) begin
      sel      <= win_s;
      pal_base <= win_pxl_s;
    end
  end
endmodule

// File: rtl/jtvigil_prio_colmix.sv
// N-layer colour mixer: priority resolution, three-read palette lookup, blanked RGB out.
module jtvigil_prio_colmix
  import jtvigil_colmix_pkg::*;
#(
  parameter int LAYERS = 3,
  parameter int PXLW   = 8,
  parameter int CW     = 5,
  parameter int LW     = 2,
  parameter int PALAW  = LW + 2 + PXLW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pxl_cen,
  input  logic                   LHBL,
  input  logic                   LVBL,
  jtvigil_prio_colmix_if.slave   cpu,
  input  logic [LAYERS*PXLW-1:0] lyr_pxl,
  input  logic [LAYERS-1:0]      gfx_en,
  output logic [CW-1:0]          red,
  output logic [CW-1:0]          green,
  output logic [CW-1:0]          blue
);
  localparam logic [15:0] RANK_ALL = default_ranks();

  logic [2*LAYERS-1:0] rank_r;
  logic [LW-1:0]       sel_s;
  logic [PXLW-1:0]     pal_base_s;
  logic [2:0]          phase_r;
  logic [CW-1:0]       pre_red_r, pre_green_r, pre_blue_r;
  logic [PALAW-1:0]    vid_addr_s;
  logic [7:0]          vid_q_s;
  logic                unused_s;

  assign vid_addr_s = {sel_s, phase_r[2:1], pal_base_s};
  assign unused_s   = ^vid_q_s[7:CW];

  // Rank table; a write lands after any coincident pxl_cen sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               rank_r <= RANK_ALL[2*LAYERS-1:0];
    else if (cpu.prio_we)  rank_r <= cpu.prio_din;
  end

  jtvigil_prio_sel #(.LAYERS(LAYERS), .PXLW(PXLW), .LW(LW)) u_sel (
    .clk      (clk),
    .rst      (rst),
    .pxl_cen  (pxl_cen),
    .lyr_pxl  (lyr_pxl),
    .ranks    (rank_r),
    .gfx_en   (gfx_en),
    .sel      (sel_s),
    .pal_base (pal_base_s)
  );

  jtframe_dual_ram #(.dw(8), .aw(PALAW)) u_pal (
    .clk0  (clk),
    .data0 (cpu.cpu_dout),
    .addr0 (cpu.cpu_addr),
    .we0   (cpu.pal_cs & ~cpu.cpu_rnw),
    .q0    (cpu.cpu_din),
    .clk1  (clk),
    .addr1 (vid_addr_s),
    .q1    (vid_q_s)
  );

  // Phase counter restarts on pxl_cen and parks at 7.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  phase_r <= 3'd0;
    else if (pxl_cen)         phase_r <= 3'd0;
    else if (phase_r != 3'd7) phase_r <= phase_r + 3'd1;
  end

  // Capture each channel one clk after its address (RAM read latency).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_red_r   <= '0;
      pre_green_r <= '0;
      pre_blue_r  <= '0;
    end else begin
      case (phase_r)
        PH_R:    pre_red_r   <= vid_q_s[CW-1:0];
        PH_G:    pre_green_r <= vid_q_s[CW-1:0];
        PH_B:    pre_blue_r  <= vid_q_s[CW-1:0];
        default: pre_red_r   <= pre_red_r;
      endcase
    end
  end

  // Stage B: blanked colour output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {red, green, blue} <= '0;
    end else if (pxl_cen) begin
      if (LHBL && LVBL) {red, green, blue} <= {pre_red_r, pre_green_r, pre_blue_r};
      else              {red, green, blue} <= '0;
    end
  end

  jtvigil_prio_colmix_chk u_chk (
    .clk     (clk),
    .rst     (rst),
    .pxl_cen (pxl_cen)
  );
endmodule

// File: tb/tb_jtvigil_prio_colmix.sv
// Scoreboard bench for jtvigil_prio_colmix (LAYERS=3, PXLW=8, CW=5).
module tb_jtvigil_prio_colmix;
  localparam int LAYERS = 3;
  localparam int PALAW  = 12;

  typedef struct packed {
    logic        v;
    logic [14:0] rgb;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pxl_cen = 1'b0;
  logic        LHBL = 1'b1;
  logic        LVBL = 1'b1;
  logic [23:0] lyr_pxl = 24'd0;
  logic [2:0]  gfx_en = 3'b111;
  logic [4:0]  red, green, blue;

  logic [7:0]  pal_m [4096];
  logic [5:0]  rank_m = 6'b10_01_00;
  sb_t         sb [$];
  int          n_chk = 0;
  int          n_fail = 0;

  jtvigil_prio_colmix_if #(.LAYERS(LAYERS), .PALAW(PALAW)) cif ();

  jtvigil_prio_colmix #(.LAYERS(3), .PXLW(8), .CW(5), .LW(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .pxl_cen (pxl_cen),
    .LHBL    (LHBL),
    .LVBL    (LVBL),
    .cpu     (cif),
    .lyr_pxl (lyr_pxl),
    .gfx_en  (gfx_en),
    .red     (red),
    .green   (green),
    .blue    (blue)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] hash(input int a);
    return 8'((a * 37) ^ ((a >> 5) * 11) ^ 8'h5A);
  endfunction

  // Independent winner model: scan from the top layer down, keep strictly better.
  function automatic logic [14:0] model_rgb(input logic [23:0] px, input logic [2:0] en,
                                            input logic [5:0] rk);
    int w, best, r, base;
    logic [7:0] p;
    logic [14:0] res;
    w = -1;
    best = 99;
    for (int i = 2; i >= 0; i--) begin
      p = px[i*8 +: 8];
      if (p[3:0] != 4'd0 && en[i]) begin
        r = (p[7:6] == 2'b11) ? 0 : int'(rk[2*i +: 2]);
        if (r < best) begin
          best = r;
          w = i;
        end
      end
    end
    if (w < 0) w = 0;
    base = int'(px[w*8 +: 8]);
    for (int c = 0; c < 3; c++) begin
      p = pal_m[w*1024 + c*256 + base];
      res[(2-c)*5 +: 5] = p[4:0];
    end
    return res;
  endfunction

  task automatic pal_wr(input int a, input logic [7:0] d);
    @(negedge clk);
    cif.cpu_addr = 12'(a);
    cif.cpu_dout = d;
    cif.cpu_rnw  = 1'b0;
    cif.pal_cs   = 1'b1;
    pal_m[a]     = d;
  endtask

  task automatic pixel(input string tag, input logic [23:0] px, input logic [2:0] en,
                       input logic hb, input logic vb, input logic pw, input logic [5:0] pd);
    sb_t e;
    @(negedge clk);
    lyr_pxl = px;
    gfx_en  = en;
    LHBL    = hb;
    LVBL    = vb;
    pxl_cen = 1'b1;
    cif.prio_we  = pw;
    cif.prio_din = pd;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      if (e.v) chk(tag, {red, green, blue}, (hb && vb) ? e.rgb : 15'd0);
    end
    sb.push_back('{1'b1, model_rgb(px, en, rank_m)});
    if (pw) rank_m = pd;
    @(negedge clk);
    pxl_cen = 1'b0;
    cif.prio_we = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    cif.cpu_addr = '0;
    cif.cpu_dout = 8'd0;
    cif.cpu_rnw  = 1'b1;
    cif.pal_cs   = 1'b0;
    cif.prio_we  = 1'b0;
    cif.prio_din = 6'd0;
    #1;
    chk("reset_rgb", {red, green, blue}, 15'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    sb.push_back('{1'b0, 15'd0});

    for (int a = 0; a < 4096; a++) pal_wr(a, hash(a));
    pal_wr(12'h425, 8'h1F);
    pal_wr(12'h525, 8'h00);
    pal_wr(12'h625, 8'h0A);
    pal_wr(12'h123, 8'h55);
    @(negedge clk);
    cif.pal_cs   = 1'b1;
    cif.cpu_rnw  = 1'b1;
    cif.cpu_addr = 12'h123;
    @(negedge clk);
    chk("cpu_rd_123", {24'd0, cif.cpu_din}, 32'h55);
    cif.cpu_addr = 12'h625;
    @(negedge clk);
    chk("cpu_rd_625", {24'd0, cif.cpu_din}, 32'h0A);
    cif.pal_cs = 1'b0;

    // Layer 1 alone, then the literal colour from the palette setup.
    pixel("l1_only_a", 24'h00_25_00, 3'b111, 1'b1, 1'b1, 1'b0, 6'd0);
    pixel("l1_only_b", 24'h00_25_00, 3'b111, 1'b1, 1'b1, 1'b0, 6'd0);
    chk("l1_lit", {red, green, blue}, {5'h1F, 5'h00, 5'h0A});

    pixel("dflt_rank", 24'h32_00_11, 3'b111, 1'b1, 1'b1, 1'b0, 6'd0);
    pixel("wr_coinc",  24'h32_00_11, 3'b111, 1'b1, 1'b1, 1'b1, 6'b00_01_10);
    pixel("new_rank",  24'h32_00_11, 3'b111, 1'b1, 1'b1, 1'b0, 6'd0);
    pixel("promo_tie", 24'h05_00_C3, 3'b111, 1'b1, 1'b1, 1'b0, 6'd0);
    pixel("promo_l0",  24'h00_00_C3, 3'b111, 1'b1, 1'b1, 1'b0, 6'd0);
    pixel("backdrop",  24'h00_00_40, 3'b111, 1'b1, 1'b1, 1'b0, 6'd0);
    pixel("gfx_off",   24'h05_07_40, 3'b011, 1'b1, 1'b1, 1'b0, 6'd0);
    pixel("hblank",    24'h05_07_40, 3'b111, 1'b0, 1'b1, 1'b0, 6'd0);
    pixel("hb_restore",24'h00_25_00, 3'b111, 1'b1, 1'b1, 1'b0, 6'd0);
    pixel("vblank",    24'h00_25_00, 3'b111, 1'b1, 1'b0, 1'b0, 6'd0);
    pixel("vb_restore",24'h32_00_11, 3'b111, 1'b1, 1'b1, 1'b0, 6'd0);

    for (int k = 0; k < 24; k++) begin
      pixel("rand", 24'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 4) != 0), 1'b1,
            1'($urandom_range(0, 3) == 0), 6'($urandom));
    end

    // Asynchronous reset in the middle of a pixel.
    pixel("pre_rst_a", 24'h00_25_00, 3'b111, 1'b1, 1'b1, 1'b0, 6'd0);
    pixel("pre_rst_b", 24'h00_25_00, 3'b111, 1'b1, 1'b1, 1'b0, 6'd0);
    chk("pre_rst_lit", {red, green, blue}, {5'h1F, 5'h00, 5'h0A});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async", {red, green, blue}, 15'd0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    sb.push_back('{1'b0, 15'd0});
    rank_m = 6'b10_01_00;
    pixel("post_rst_a", 24'h32_00_11, 3'b111, 1'b1, 1'b1, 1'b0, 6'd0);
    chk("post_rst_zero", {red, green, blue}, 15'd0);
    pixel("post_rst_b", 24'h00_25_00, 3'b111, 1'b1, 1'b1, 1'b0, 6'd0);
    pixel("post_rst_c", 24'h00_00_00, 3'b111, 1'b1, 1'b1, 1'b0, 6'd0);
    chk("post_rst_lit", {red, green, blue}, {5'h1F, 5'h00, 5'h0A});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
